// File: rtl/note_keyboard_ctl.sv
// note_keyboard_ctl
// Keyboard-to-audio front end: NUM_KEYS debounced note keys plus debounced
// volume up/down buttons drive an attack/sustain/release envelope that scales
// a square wave. The 16-bit sample goes straight to speaker_ctl.
//
// Optional build macro: KEY_LATCH_EN
//   undefined : a note sounds while its key is held (momentary).
//   defined   : tapping a key latches it as the sounding note; tapping the
//               latched key again releases it; tapping another key switches.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   key_n             note buttons, active low, bit i -> note_table slot i
//   vol_up_n/vol_dn_n volume buttons, active low
//   note_table        flattened half-period dividers, slot i = [i*DIV_W +: DIV_W]
//   audio_left/right  signed sample (identical), registered
//   note_div          divider currently sounding, 0 = silent
//   level             volume level 0..LEVEL_MAX
//   level_bcd1/0      tens/units digits of level (one cycle behind level)
//   LED               thermometer bar LED[i] = (i < level) (one cycle behind)
//   note_active       envelope is not idle
//   dbg_state         envelope state (0 idle, 1 attack, 2 sustain, 3 release)
//
// Handshakes: none. Buttons are level inputs, outputs are free-running.
module note_keyboard_ctl #(
  parameter int          NUM_KEYS    = 8,
  parameter int          DIV_W       = 20,
  parameter int          LEVEL_MAX   = 15,
  parameter int          LEVEL_INIT  = 8,
  parameter logic [15:0] AMP_STEP    = 16'h0800,
  parameter int          DEB_CYCLES  = 100000,
  parameter int          RAMP_CYCLES = 50000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_KEYS-1:0]       key_n,
  input  logic                      vol_up_n,
  input  logic                      vol_dn_n,
  input  logic [NUM_KEYS*DIV_W-1:0] note_table,
  output logic [15:0]               audio_left,
  output logic [15:0]               audio_right,
  output logic [DIV_W-1:0]          note_div,
  output logic [4:0]                level,
  output logic [3:0]                level_bcd1,
  output logic [3:0]                level_bcd0,
  output logic [15:0]               LED,
  output logic                      note_active,
  output logic [1:0]                dbg_state
);

  localparam int NB  = NUM_KEYS + 2;  // keys, then vol_up, then vol_dn
  localparam int DCW = $clog2(DEB_CYCLES + 1);
  localparam int RCW = $clog2(RAMP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3} env_state_e;

  function automatic logic [3:0] tens_of(input logic [4:0] lvl);
    return (lvl >= 5'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic logic [3:0] units_of(input logic [4:0] lvl);
    return (lvl >= 5'd10) ? 4'(lvl - 5'd10) : lvl[3:0];
  endfunction

  function automatic logic [15:0] bar_of(input logic [4:0] lvl);
    logic [15:0] b;
    for (int i = 0; i < 16; i++) b[i] = (5'(i) < lvl);
    return b;
  endfunction

  // ---------------- button synchronise + debounce (1 = pressed) ----------
  logic [NB-1:0]  btn_raw, sync1_q, sync2_q, deb_q, deb_d, press;
  logic [DCW-1:0] dcnt_q [NB];
  logic [DCW-1:0] dcnt_d [NB];

  assign btn_raw = {~vol_dn_n, ~vol_up_n, ~key_n};

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = '0;  // any agreement (including a bounce back) clears the count
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DCW'(DEB_CYCLES - 1)) deb_d[i] = ~deb_q[i];
        else                                   dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  assign press = deb_d & ~deb_q;

  // ---------------- volume level ----------------
  logic [4:0]  level_q, level_d;
  logic [3:0]  bcd1_q, bcd0_q;
  logic [15:0] led_q;
  logic        vol_up, vol_dn;

  assign vol_up = press[NUM_KEYS];
  assign vol_dn = press[NUM_KEYS+1];

  always_comb begin
    level_d = level_q;
    if (vol_up && !vol_dn && level_q != 5'(LEVEL_MAX)) level_d = level_q + 5'd1;
    else if (vol_dn && !vol_up && level_q != 5'd0)     level_d = level_q - 5'd1;
  end

  // ---------------- key source ----------------
  logic [NUM_KEYS-1:0] key_src;
`ifdef KEY_LATCH_EN
  logic [NUM_KEYS-1:0] latch_q, latch_d;

  // Descending scan so the lowest-index press edge decides.
  always_comb begin
    latch_d = latch_q;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press[i]) latch_d = latch_q[i] ? '0 : (NUM_KEYS'(1) << i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) latch_q <= '0;
    else       latch_q <= latch_d;
  end

  assign key_src = latch_q;
`else
  assign key_src = deb_q[NUM_KEYS-1:0];
`endif

  logic [DIV_W-1:0] sel_div;
  logic             any_key;

  always_comb begin
    sel_div = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_src[i]) sel_div = note_table[i*DIV_W +: DIV_W];
    end
  end

  assign any_key = |key_src;

  // ---------------- envelope ----------------
  env_state_e       state_q, state_d;
  logic [15:0]      amp_q, amp_d, target, amp_up, amp_dn, amp_to_t;
  logic [16:0]      amp_sum;
  logic [DIV_W-1:0] div_q, div_d;
  logic [RCW-1:0]   rcnt_q, rcnt_d;
  logic             tick;

  assign target  = 16'(level_q * AMP_STEP);
  assign amp_sum = {1'b0, amp_q} + {1'b0, AMP_STEP};
  assign amp_up  = (amp_sum > {1'b0, target}) ? target : amp_sum[15:0];
  assign amp_dn  = (amp_q > AMP_STEP) ? (amp_q - AMP_STEP) : 16'd0;
  // Downward step that stops at the target (volume lowered while sustaining).
  assign amp_to_t = ((amp_q - target) > AMP_STEP) ? (amp_q - AMP_STEP) : target;

  assign tick   = (state_q != IDLE) && (rcnt_q == RCW'(RAMP_CYCLES - 1));
  assign rcnt_d = (state_q == IDLE || tick) ? '0 : rcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    amp_d   = amp_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        if (any_key) begin
          div_d   = sel_div;
          state_d = ATTACK;
        end
      end
      ATTACK: begin
        if (!any_key)             state_d = RELEASE;
        else if (amp_q == target) state_d = SUSTAIN;
        else if (tick)            amp_d   = amp_up;
      end
      SUSTAIN: begin
        if (!any_key) begin
          state_d = RELEASE;
        end else begin
          div_d = sel_div;  // key change swaps pitch without touching amp
          if (tick) begin
            if (amp_q < target)      amp_d = amp_up;
            else if (amp_q > target) amp_d = amp_to_t;
          end
        end
      end
      RELEASE: begin
        if (any_key) begin
          div_d   = sel_div;
          state_d = ATTACK;
        end else if (amp_q == 16'd0) begin
          div_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          amp_d = amp_dn;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- tone generator ----------------
  logic [DIV_W-1:0] pc_q, pc_d;
  logic             phase_q, phase_d;
  logic [15:0]      sample_q, sample_d;

  always_comb begin
    pc_d    = pc_q + 1'b1;
    phase_d = phase_q;
    if (div_d == '0) begin
      pc_d    = '0;
      phase_d = 1'b0;
    end else if (div_d != div_q) begin
      pc_d = '0;
    end else if (pc_q == div_q - 1'b1) begin
      pc_d    = '0;
      phase_d = ~phase_q;
    end
  end

  assign sample_d = (div_q == '0) ? 16'd0 : (phase_q ? amp_q : (~amp_q + 16'd1));

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      for (int i = 0; i < NB; i++) dcnt_q[i] <= '0;
      level_q  <= 5'(LEVEL_INIT);
      bcd1_q   <= tens_of(5'(LEVEL_INIT));
      bcd0_q   <= units_of(5'(LEVEL_INIT));
      led_q    <= bar_of(5'(LEVEL_INIT));
      state_q  <= IDLE;
      amp_q    <= '0;
      div_q    <= '0;
      rcnt_q   <= '0;
      pc_q     <= '0;
      phase_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      for (int i = 0; i < NB; i++) dcnt_q[i] <= dcnt_d[i];
      level_q  <= level_d;
      bcd1_q   <= tens_of(level_q);
      bcd0_q   <= units_of(level_q);
      led_q    <= bar_of(level_q);
      state_q  <= state_d;
      amp_q    <= amp_d;
      div_q    <= div_d;
      rcnt_q   <= rcnt_d;
      pc_q     <= pc_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
    end
  end

  assign audio_left  = sample_q;
  assign audio_right = sample_q;
  assign note_div    = div_q;
  assign level       = level_q;
  assign level_bcd1  = bcd1_q;
  assign level_bcd0  = bcd0_q;
  assign LED         = led_q;
  assign note_active = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule
